// File: rtl/dice_pkg.sv
// Shared types and constants for the dice result stabilizer.
// Holds the FSM state encoding, colour codes and default thresholds.
package dice_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TRACK   = 2'd1,
      S_FIRE    = 2'd2,
      S_LOCKOUT = 2'd3
   } state_e;

   localparam logic [1:0] COLOR_NONE = 2'd0;
   localparam logic [1:0] FACE1      = 2'd1;
   localparam logic [1:0] FACE2      = 2'd2;
   localparam logic [1:0] FACE3      = 2'd3;

   localparam int STABLE_FRAMES_DEF = 8;
   localparam int CLEAR_FRAMES_DEF  = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together load the value 1.
module sat_counter #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] ONE_V = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = inc_i ? ONE_V : '0;
      end else if (inc_i && count_q != MAX_V) begin
         count_d = count_q + ONE_V;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/dice_result_stabilizer.sv
// Accepts a dice roll once the camera reports the same face for enough
// consecutive frames, then locks out until the tray is seen empty.
module dice_result_stabilizer
   import dice_pkg::*;
#(
   parameter int STABLE_FRAMES = STABLE_FRAMES_DEF,
   parameter int CLEAR_FRAMES  = CLEAR_FRAMES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       frame_done,
   input  logic [1:0] color_code,
   output logic       result_ready,
   output logic [1:0] stable_color,
   output logic       locked
);

   localparam int CW = $clog2(STABLE_FRAMES + 1);
   localparam int KW = $clog2(CLEAR_FRAMES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_FRAMES - 1);
   localparam logic [KW-1:0] CLR_LAST = KW'(CLEAR_FRAMES - 1);

   state_e     state_q;
   state_e     state_d;
   logic [1:0] cand_q;
   logic [1:0] cand_d;
   logic       result_ready_q;
   logic [1:0] stable_color_q;
   logic       locked_q;

   logic          cnt_clr;
   logic          cnt_inc;
   logic [CW-1:0] cnt;
   logic          clr_clr;
   logic          clr_inc;
   logic [KW-1:0] clr_cnt;

   sat_counter #(
      .W   (CW),
      .MAX (STABLE_FRAMES)
   ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .count_o (cnt)
   );

   sat_counter #(
      .W   (KW),
      .MAX (CLEAR_FRAMES)
   ) u_clr_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (clr_clr),
      .inc_i   (clr_inc),
      .count_o (clr_cnt)
   );

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      clr_clr = 1'b0;
      clr_inc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (frame_done && enable && color_code != COLOR_NONE) begin
               cand_d  = color_code;
               cnt_clr = 1'b1;
               cnt_inc = 1'b1;
               state_d = S_TRACK;
            end
         end
         S_TRACK: begin
            // Dropping enable wins over a frame landing in the same cycle
            if (!enable) begin
               cnt_clr = 1'b1;
               state_d = S_IDLE;
            end else if (frame_done) begin
               if (color_code == COLOR_NONE) begin
                  cnt_clr = 1'b1;
                  state_d = S_IDLE;
               end else if (color_code == cand_q) begin
                  cnt_inc = 1'b1;
                  if (cnt >= CNT_LAST) begin
                     state_d = S_FIRE;
                  end
               end else begin
                  cand_d  = color_code;
                  cnt_clr = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
         end
         S_FIRE: begin
            cnt_clr = 1'b1;
            clr_clr = 1'b1;
            state_d = S_LOCKOUT;
         end
         S_LOCKOUT: begin
            if (frame_done) begin
               if (color_code != COLOR_NONE) begin
                  clr_clr = 1'b1;
               end else if (clr_cnt >= CLR_LAST) begin
                  clr_clr = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  clr_inc = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they align with it
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cand_q         <= '0;
         result_ready_q <= 1'b0;
         stable_color_q <= '0;
         locked_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cand_q         <= cand_d;
         result_ready_q <= (state_d == S_FIRE);
         locked_q       <= (state_d == S_LOCKOUT);
         if (state_d == S_FIRE) begin
            stable_color_q <= cand_d;
         end
      end
   end

   assign result_ready = result_ready_q;
   assign stable_color = stable_color_q;
   assign locked       = locked_q;

endmodule
